// File: rtl/flopenr_pkg.sv
// Shared constants, types and helpers for the flopenr_pipe stall/flush pipeline.
package flopenr_pkg;

  localparam int unsigned DEPTH_MAX = 16;

  // Per-stage control: incoming valid bit and load enable.
  typedef struct packed {
    logic valid;
    logic load;
  } stage_ctl_t;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/flopenr_stage.sv
// One valid+data pipeline register with load enable and synchronous valid clear.
// Carries a parity bit alongside the data when FLOPENR_PIPE_PARITY_EN is defined.
module flopenr_stage
  import flopenr_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  stage_ctl_t       ctl,
  input  logic             clr,
  input  logic [WIDTH-1:0] d_in,
`ifdef FLOPENR_PIPE_PARITY_EN
  input  logic             par_in,
  output logic             par,
`endif
  output logic             v,
  output logic [WIDTH-1:0] d
);

  // Valid bit: flush clear wins over load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= 1'b0;
    end else if (clr) begin
      v <= 1'b0;
    end else if (ctl.load) begin
      v <= ctl.valid;
    end
  end

  // Payload is written only by a valid word; bubbles leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d <= '0;
`ifdef FLOPENR_PIPE_PARITY_EN
      par <= 1'b0;
`endif
    end else if (!clr && ctl.load && ctl.valid) begin
      d <= d_in;
`ifdef FLOPENR_PIPE_PARITY_EN
      par <= par_in;
`endif
    end
  end

endmodule

// File: rtl/flopenr_pipe.sv
// DEPTH-stage valid/ready pipeline with global stall, synchronous flush and bubble squashing.
// Optional per-stage even parity and out_parity_err port via FLOPENR_PIPE_PARITY_EN.
module flopenr_pipe
  import flopenr_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 3
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
`ifdef FLOPENR_PIPE_PARITY_EN
  output logic                     out_parity_err,
`endif
  output logic [cnt_w(DEPTH)-1:0]  count
);

  localparam int unsigned CNT_W = cnt_w(DEPTH);

  if (DEPTH == 0 || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("flopenr_pipe: DEPTH must be within 1..16");
  end

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH:0]   rdy;
  logic             adv;
  logic             clr;
  logic             in_xfer;
  logic             out_xfer;
`ifdef FLOPENR_PIPE_PARITY_EN
  logic [DEPTH-1:0] par;
`endif

  assign adv = en & ~flush;
  assign clr = en & flush;

  // rdy[i]: some stage at or after i is empty, or the sink accepts.
  assign rdy[DEPTH] = out_ready;
  for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
    assign rdy[i] = out_ready | ~(&v[DEPTH-1:i]);
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    stage_ctl_t       ctl;
    logic             src_v;
    logic [WIDTH-1:0] src_d;
`ifdef FLOPENR_PIPE_PARITY_EN
    logic             src_par;
`endif

    if (i == 0) begin : g_head
      assign src_v = in_valid;
      assign src_d = in_data;
`ifdef FLOPENR_PIPE_PARITY_EN
      assign src_par = ^in_data;
`endif
    end else begin : g_body
      assign src_v = v[i-1];
      assign src_d = d[i-1];
`ifdef FLOPENR_PIPE_PARITY_EN
      assign src_par = par[i-1];
`endif
    end

    assign ctl = '{valid: src_v, load: adv & rdy[i]};

    flopenr_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk    (clk_in),
      .rst_n  (rst_in),
      .ctl    (ctl),
      .clr    (clr),
      .d_in   (src_d),
`ifdef FLOPENR_PIPE_PARITY_EN
      .par_in (src_par),
      .par    (par[i]),
`endif
      .v      (v[i]),
      .d      (d[i])
    );
  end

  // Gate in_ready with reset so nothing is offered acceptance while held in reset.
  assign in_ready  = rst_in & adv & rdy[0];
  assign out_valid = adv & v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

`ifdef FLOPENR_PIPE_PARITY_EN
  assign out_parity_err = out_valid & ((^out_data) != par[DEPTH-1]);
`endif

  // Occupancy counter mirrors the number of valid stages.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (in_xfer && !out_xfer) begin
      count <= count + CNT_W'(1);
    end else if (!in_xfer && out_xfer) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_flopenr_pipe.sv
// Scoreboard bench for flopenr_pipe: directed scenarios then randomized traffic.
module tb_flopenr_pipe;
  import flopenr_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned CNT_W = cnt_w(DEPTH);
  localparam int          D     = int'(DEPTH);

  logic             clk_in    = 1'b0;
  logic             rst_in    = 1'b0;
  logic             en        = 1'b0;
  logic             flush     = 1'b0;
  logic             in_valid  = 1'b0;
  logic [WIDTH-1:0] in_data   = '0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] count;
`ifdef FLOPENR_PIPE_PARITY_EN
  logic             out_parity_err;
  logic             corrupt = 1'b0;
  logic [WIDTH-1:0] bad_word;
`endif

  int total = 0;
  int bad   = 0;

  // Words inside the pipe, oldest first, with their stage position.
  logic [WIDTH-1:0] exp_q[$];
  int               pos_q[$];

  flopenr_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .en            (en),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
`ifdef FLOPENR_PIPE_PARITY_EN
    .out_parity_err(out_parity_err),
`endif
    .count         (count)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare against the model mid-cycle, then advance the model for the next edge.
  always @(negedge clk_in) begin
    int  n;
    bit  e_in_ready;
    bit  e_out_valid;
    bit  out_x;
    bit  in_x;
    if (!rst_in) begin
      exp_q.delete();
      pos_q.delete();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_count", 32'(count), 32'd0);
    end else begin
      n           = exp_q.size();
      e_out_valid = en && !flush && n > 0 && pos_q[0] == D - 1;
      e_in_ready  = en && !flush && (n < D || out_ready);
      check("in_ready", 32'(in_ready), 32'(e_in_ready));
      check("out_valid", 32'(out_valid), 32'(e_out_valid));
      check("count", 32'(count), 32'(n));
      out_x = e_out_valid && out_ready;
      in_x  = in_valid && e_in_ready;
      if (out_x) check("out_data", 32'(out_data), 32'(exp_q[0]));
`ifdef FLOPENR_PIPE_PARITY_EN
      check("parity_err", 32'(out_parity_err), corrupt ? 32'(e_out_valid) : 32'd0);
`endif
      if (en) begin
        if (flush) begin
          exp_q.delete();
          pos_q.delete();
        end else begin
          // A word advances when the sink accepts or a hole exists ahead of it.
          for (int k = 0; k < n; k++) begin
            if (pos_q[k] < D - 1 && (out_ready || k < D - 1 - pos_q[k]))
              pos_q[k] = pos_q[k] + 1;
          end
          if (out_x) begin
            void'(exp_q.pop_front());
            void'(pos_q.pop_front());
          end
          if (in_x) begin
            exp_q.push_back(in_data);
            pos_q.push_back(0);
          end
        end
      end
    end
  end

  task automatic cyc(input bit iv, input logic [31:0] dat, input bit ordy);
    in_valid  = iv;
    in_data   = WIDTH'(dat);
    out_ready = ordy;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    en = 1'b1;
    repeat (2) cyc(1'b0, 32'h0, 1'b0);
    rst_in = 1'b1;

    // Back-to-back stream with free sink.
    cyc(1'b1, 32'h1, 1'b1);
    cyc(1'b1, 32'h2, 1'b1);
    cyc(1'b1, 32'h3, 1'b1);
    repeat (4) cyc(1'b0, 32'h0, 1'b1);

    // Reset in the middle of a stream discards everything.
    cyc(1'b1, 32'h11, 1'b1);
    cyc(1'b1, 32'h12, 1'b1);
    rst_in = 1'b0;
    cyc(1'b1, 32'h13, 1'b1);
    rst_in = 1'b1;
    repeat (4) cyc(1'b0, 32'h0, 1'b1);

    // Backpressure until full, then simultaneous in/out.
    cyc(1'b1, 32'hA, 1'b0);
    cyc(1'b1, 32'hB, 1'b0);
    cyc(1'b1, 32'hC, 1'b0);
    repeat (3) cyc(1'b1, 32'hD, 1'b0);
    cyc(1'b1, 32'hD, 1'b1);
    repeat (5) cyc(1'b0, 32'h0, 1'b1);

    // Bubble collapse against a blocked sink.
    cyc(1'b1, 32'h5, 1'b0);
    repeat (2) cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h6, 1'b0);
    repeat (2) cyc(1'b0, 32'h0, 1'b0);

    // Stall holds everything, then drain resumes.
    en = 1'b0;
    repeat (4) cyc(1'b1, 32'h77, 1'b1);
    en = 1'b1;
    repeat (4) cyc(1'b0, 32'h0, 1'b1);

    // Flush a full pipe, then a fresh word flows through.
    cyc(1'b1, 32'h21, 1'b0);
    cyc(1'b1, 32'h22, 1'b0);
    cyc(1'b1, 32'h23, 1'b0);
    flush = 1'b1;
    cyc(1'b1, 32'h99, 1'b1);
    flush = 1'b0;
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b1, 32'h7, 1'b1);
    repeat (5) cyc(1'b0, 32'h0, 1'b1);

    // Randomized traffic with occasional stall, flush and reset.
    for (int i = 0; i < 800; i++) begin
      en     = ($urandom_range(0, 9) != 0);
      flush  = ($urandom_range(0, 29) == 0);
      rst_in = ($urandom_range(0, 99) != 0);
      cyc(1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 2) != 0));
    end
    en     = 1'b1;
    flush  = 1'b0;
    rst_in = 1'b1;
    repeat (6) cyc(1'b0, 32'h0, 1'b1);

`ifdef FLOPENR_PIPE_PARITY_EN
    // Corrupt the last stage's data so its stored parity no longer matches.
    repeat (3) cyc(1'b1, $urandom, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    bad_word = out_data ^ WIDTH'(1);
    corrupt  = 1'b1;
    force dut.g_stage[2].u_stage.d = bad_word;
    cyc(1'b0, 32'h0, 1'b0);
    release dut.g_stage[2].u_stage.d;
    flush = 1'b1;
    cyc(1'b0, 32'h0, 1'b0);
    flush   = 1'b0;
    corrupt = 1'b0;
    repeat (4) cyc(1'b1, $urandom, 1'b1);
    repeat (5) cyc(1'b0, 32'h0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flopenr_pipe.md
Name: flopenr_pipe

Overview:
- Parametrised successor to the single enabled register: a chain of DEPTH enabled register stages, each WIDTH bits wide, with a per-stage valid bit.
- Valid/ready handshakes on input and output, plus a global stall enable and a synchronous flush.
- Empty stages are collapsed (bubble squashing), so the chain sustains one transfer per cycle.
- Serves as the generic stall/flush pipeline and elastic buffer between MIPS datapath stages.

Parameters:
- WIDTH, 32, data bits per stage.
- DEPTH, 3, number of register stages; legal range 1..16; elaboration error outside it.

Ports:
- clk_in  input  1  clock; all state updates on its rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- en  input  1  global enable; 0 freezes all stages (stall).
- flush  input  1  synchronous clear of all valid bits.
- in_valid  input  1  upstream offers in_data.
- in_data  input  WIDTH  payload.
- in_ready  output  1  stage 0 can accept this cycle.
- out_valid  output  1  last stage holds valid data.
- out_data  output  WIDTH  payload of stage DEPTH-1.
- out_ready  input  1  downstream accepts this cycle.
- count  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Reset: rst_in=0 asynchronously clears every valid bit and data register to 0. While in reset, in_ready=0, out_valid=0, out_data=0 and count=0. A reset mid-transfer discards all data; nothing is replayed.
- Stage model: stage i holds v[i] and d[i]. Define rdy[DEPTH] = out_ready and rdy[i] = ~v[i] | rdy[i+1]. This is a combinational chain; a full chain with out_ready=1 gives rdy[0]=1.
- Handshakes:
  - in_ready = en & ~flush & rdy[0].
  - out_valid = en & ~flush & v[DEPTH-1].
  - out_data = d[DEPTH-1], always driven, independent of en.
  - Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- Stage advance (en=1, flush=0):
  - Stage i loads when rdy[i] is 1.
  - On load: d[i] <= d[i-1] and v[i] <= v[i-1]. For stage 0 the source is in_data/in_valid.
  - d[i] is written only when the incoming valid is 1. On a bubble, d[i] holds its value and only v[i] clears.
  - A stage that does not load holds both v[i] and d[i].
- Stall: en=0 holds all state, including count. in_valid/out_ready are ignored and no transfer occurs.
- Flush:
  - flush=1 with en=1 clears all v[i] at the next edge.
  - d[i] is unchanged.
  - The input is not accepted and out_valid=0 that cycle.
  - flush has priority over load.
- flush with en=0: no effect (stall dominates).
- Latency: an accepted word reaches out_valid DEPTH cycles later when the chain is empty and never stalled. Throughput is 1 word/cycle.
- Full: count=DEPTH.
  - out_ready=0 gives in_ready=0.
  - out_ready=1 allows simultaneous in and out transfers; count stays DEPTH.
- Bubble collapse: an empty stage i loads from i-1 even when downstream is stalled, so in_ready stays 1 until all DEPTH stages are valid.
- count: registered. It updates by +1 on input-only transfers, -1 on output-only transfers, and is unchanged when both or neither occur. Flush sets it to 0. It never exceeds DEPTH and never underflows.
- Ordering: strict FIFO; no word is duplicated or dropped except by flush or reset.

Optional Feature:
- Macro FLOPENR_PIPE_PARITY_EN.
- When defined:
  - Each stage stores an even-parity bit computed from in_data at stage-0 load and carried with the data.
  - An extra output port out_parity_err (1 bit) is added: out_valid & (^out_data != stored parity).
  - It resets to 0 and is purely combinational from stage DEPTH-1.
- When undefined: no parity storage and no out_parity_err port; all other behaviour is identical.

Decomposition:
- Package flopenr_pkg:
  - DEPTH_MAX=16 constant.
  - Function cnt_w(depth) returning $clog2(depth+1).
  - typedef stage_ctl_t {valid, load} for stage control.
- Sub-module flopenr_stage (WIDTH):
  - One valid+data register with load enable, async active-low clear and synchronous valid clear.
  - Includes the parity bit when FLOPENR_PIPE_PARITY_EN is defined.
- flopenr_pipe generates DEPTH instances and the rdy chain.

Test Plan:
- Reset then stream (DEPTH=3, WIDTH=32):
  - Assert rst_in=0 mid-stream -> out_valid=0, count=0 immediately.
  - Release reset; in_valid=1 with 0x00000001, 0x00000002, 0x00000003 back-to-back, out_ready=1, en=1 -> out_data 0x1/0x2/0x3 valid on cycles 3, 4, 5 after first accept; count peaks at 3.
- Backpressure/full:
  - out_ready=0, push 0xA,0xB,0xC,0xD -> in_ready drops after the 3rd accept; count=3; 0xD held by source.
  - Raise out_ready -> 0xA out and 0xD accepted in the same cycle; count stays 3.
- Bubble collapse: push 0x5, idle 2 cycles, push 0x6 with out_ready=0 -> both collapse to stages 2 and 1; count=2; in_ready=1.
- Stall: en=0 for 4 cycles with in_valid=1, out_ready=1 and count=2 -> no transfers, state and count unchanged. en=1 -> drain resumes in order.
- Flush: count=3, assert flush=1 for 1 cycle with in_valid=1 -> no accept, out_valid=0; next cycle count=0, out_valid=0. A subsequent push of 0x7 emerges after 3 cycles.
- Parity (macro defined): corrupt d[2] by force via hierarchical path -> out_parity_err=1 while out_valid=1. Clean traffic -> out_parity_err=0 throughout.
